keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
Scans the calculator's 6-column x 4-row key matrix, debounces it and turns each accepted key press into exactly one single-cycle event. Its outputs are newhex, hexcode, newop, eq and BS, which drive the operand register block and the operator logic. Each press yields one event regardless of hold time. Bounce, glitches and multi-key chords never produce events.

Parameters:
SCAN_DIV, 4, clock cycles each column is driven; legal range 4..255.
DEBOUNCE_SCANS, 3, consecutive identical full scans needed to accept a press or a release; legal range 1..15.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
col_n  output  6  column drive, one-hot active-low
row_n  input  4  row sense, active-low; asynchronous to clock (pulled up off-chip)
newhex  output  1  one-cycle pulse: hex key 0..F accepted
hexcode  output  4  value of the last hex key; valid with newhex, held afterwards
newop  output  1  one-cycle pulse: operator key accepted
opcode  output  2  00 add, 01 sub, 10 mul; valid with newop, held afterwards
eq  output  1  one-cycle pulse: equals key accepted
BS  output  1  one-cycle pulse: backspace key accepted
clr  output  1  one-cycle pulse: clear key accepted

Behaviour:
- Clocking and reset: one clock, named clock. Reset is named reset and is synchronous, active-high.
- Reset values: col_n=6'b111110; newhex, newop, eq, BS and clr are 0; hexcode=0; opcode=0. State is IDLE and all counters and synchronizers are cleared.
- Row synchronizer: row_n passes through 2 flops before use.
- Column scan:
  - Column c is held low for SCAN_DIV cycles, then the next column is driven (0..5, wrapping to 0).
  - Scanning runs continuously in every state.
  - The synchronized rows are sampled in the last cycle of each column slot.
- Key index: idx = col*4 + row. The key map is:
  - Cols 0..3 are hex keys; hexcode = idx.
  - Col 4: row0 +, row1 -, row2 *, row3 unused.
  - Col 5: row0 eq, row1 BS, row2 clr, row3 unused.
- Scan result: evaluated after the col-5 sample.
  - NONE: no key seen.
  - KEY(idx): exactly one key seen.
  - MULTI: two or more keys seen; treated as distinct from every KEY.
- Debounce counter cnt: cnt increments when the current scan result equals the previous one. Otherwise it resets to 1.
- State machine:
  - IDLE: when the result is KEY(k) and cnt reaches DEBOUNCE_SCANS, go to HELD. The matching event pulses on the next cycle. Unused keys go to HELD with no pulse.
  - HELD: no events are emitted. Go to IDLE when the result is NONE and cnt reaches DEBOUNCE_SCANS.
  - MULTI is never accepted in any state. In HELD, any non-NONE result keeps the state at HELD.
- Latency: from the final qualifying col-5 sample to the pulse is 1 cycle.
- Pulse width: exactly 1 cycle, and at most one pulse output is high in any cycle.
- hexcode and opcode update only together with their own pulse.
- Reset during HELD or a partial debounce returns to IDLE. A key still held after reset is debounced afresh and produces a new event.
- The counter saturates at DEBOUNCE_SCANS and never wraps.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (IDLE, HELD);
  - the opcode constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10);
  - the key index constants (KEY_ADD=16, KEY_SUB=17, KEY_MUL=18, KEY_EQ=20, KEY_BS=21, KEY_CLR=22);
  - the scan result encoding: a 5-bit index, plus NONE=5'd31 and MULTI=5'd30.
- Sub-module key_debounce takes the per-scan result and a scan-done strobe. It outputs an accepted-press strobe with its index, and the release condition.
- Column timing, the synchronizer and pulse decode stay in the top level.

Test Plan:
(All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, so one full scan is 24 cycles.)
1. Reset with no keys -> all outputs 0 and col_n=111110; col_n=111101 at cycle 4 and 111110 again at cycle 24; no pulses for 20 scans.
2. Hold key A (col2,row2) steady from cycle 0 -> exactly one newhex pulse with hexcode=4'hA, 1 cycle after the 3rd full scan. Keep holding for 10 more scans -> no further pulses, hexcode stays A.
3. Key 5 toggles on alternate scans for 4 scans, then stays steady -> no pulse during the toggling. One newhex with hexcode=5 after 3 steady scans.
4. Press * (col4,row2), release for 3 scans, then press eq (col5,row0) -> newop with opcode=10 first, then one eq pulse. If the release lasts only 2 scans before eq is pressed -> no eq pulse until eq is released and pressed again.
5. Hold keys 3 and 7 together for 5 scans -> no pulse. Release 7 and keep 3 -> one newhex with hexcode=3 after 3 scans.
6. Hold BS until its pulse, then assert reset for 2 cycles while still holding -> outputs 0 during and after reset, then one new BS pulse after 3 scans. Separately, press unused key (col4,row3) -> no pulses on any output.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the calculator keypad scanner.
package keypad_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam int unsigned RES_W = 5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  // Key indices are col*4 + row; indices 0..15 are the hex keys.
  localparam logic [RES_W-1:0] KEY_HEX_LAST = 5'd15;
  localparam logic [RES_W-1:0] KEY_ADD      = 5'd16;
  localparam logic [RES_W-1:0] KEY_SUB      = 5'd17;
  localparam logic [RES_W-1:0] KEY_MUL      = 5'd18;
  localparam logic [RES_W-1:0] KEY_EQ       = 5'd20;
  localparam logic [RES_W-1:0] KEY_BS       = 5'd21;
  localparam logic [RES_W-1:0] KEY_CLR      = 5'd22;

  // Scan result codes that are not a single key.
  localparam logic [RES_W-1:0] RES_NONE  = 5'd31;
  localparam logic [RES_W-1:0] RES_MULTI = 5'd30;

  function automatic logic res_is_key(input logic [RES_W-1:0] res);
    return (res != RES_NONE) && (res != RES_MULTI);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Counts consecutive identical full-scan results and flags a stable
// single-key press or a stable all-released matrix.
//   clock, reset   : clock, synchronous active-high reset
//   scan_done      : strobe in the cycle a full scan result is valid
//   scan_res       : key index, RES_NONE or RES_MULTI
//   press_c        : stable single key reached the debounce threshold
//   press_idx_c    : index of that key
//   release_c      : stable no-key result reached the debounce threshold
module key_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             scan_done,
  input  logic [RES_W-1:0] scan_res,
  output logic             press_c,
  output logic [RES_W-1:0] press_idx_c,
  output logic             release_c
);

  localparam int unsigned CW = 4;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [RES_W-1:0] prev_res;

  // Saturating run-length of the current result.
  always_comb begin
    cnt_next = CW'(1);
    if (scan_res == prev_res) begin
      cnt_next = (cnt < CW'(DEBOUNCE_SCANS)) ? cnt + CW'(1) : cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      prev_res <= RES_NONE;
    end else if (scan_done) begin
      cnt      <= cnt_next;
      prev_res <= scan_res;
    end
  end

  // Decisions use the updated count so the event follows the final scan directly.
  assign press_c     = scan_done && res_is_key(scan_res) && (cnt_next == CW'(DEBOUNCE_SCANS));
  assign release_c   = scan_done && (scan_res == RES_NONE) && (cnt_next == CW'(DEBOUNCE_SCANS));
  assign press_idx_c = scan_res;

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 6x4 key matrix, debounces it and emits one pulse per accepted press.
//   clock, reset : clock, synchronous active-high reset
//   col_n        : one-hot active-low column drive
//   row_n        : active-low row sense (asynchronous)
//   newhex/hexcode, newop/opcode, eq, BS, clr : single-cycle key events
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  output logic [5:0] col_n,
  input  logic [3:0] row_n,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic [1:0] opcode,
  output logic       eq,
  output logic       BS,
  output logic       clr
);

  localparam int unsigned DW = 8;

  logic [DW-1:0]    div_cnt;
  logic [2:0]       col;
  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [1:0]       acc_cnt;
  logic [RES_W-1:0] acc_idx;
  logic [1:0]       acc_cnt_c;
  logic [RES_W-1:0] acc_idx_c;
  logic [RES_W-1:0] scan_res_c;
  logic             sample_c;
  logic             scan_done_c;
  logic             press_c;
  logic [RES_W-1:0] press_idx_c;
  logic             release_c;

  state_t     state, state_next;
  logic       newhex_d, newop_d, eq_d, bs_d, clr_d;
  logic [3:0] hexcode_d;
  logic [1:0] opcode_d;

  // Row synchronizer.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  assign sample_c    = (div_cnt == DW'(SCAN_DIV - 1));
  assign scan_done_c = sample_c && (col == 3'd5);

  // Column timing: rotate the low column every SCAN_DIV cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      col     <= '0;
      col_n   <= 6'b111110;
    end else if (sample_c) begin
      div_cnt <= '0;
      col     <= (col == 3'd5) ? 3'd0 : col + 3'd1;
      col_n   <= {col_n[4:0], col_n[5]};
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Fold this column's rows into the running scan: 0, 1 or 2+ keys seen.
  always_comb begin
    acc_cnt_c = acc_cnt;
    acc_idx_c = acc_idx;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        if (acc_cnt_c == 2'd0) begin
          acc_idx_c = {col, 2'(r)};
          acc_cnt_c = 2'd1;
        end else begin
          acc_cnt_c = 2'd2;
        end
      end
    end
    scan_res_c = (acc_cnt_c == 2'd0) ? RES_NONE :
                 (acc_cnt_c == 2'd1) ? acc_idx_c : RES_MULTI;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_cnt <= '0;
      acc_idx <= '0;
    end else if (sample_c) begin
      acc_cnt <= scan_done_c ? 2'd0 : acc_cnt_c;
      acc_idx <= acc_idx_c;
    end
  end

  key_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .scan_done  (scan_done_c),
    .scan_res   (scan_res_c),
    .press_c    (press_c),
    .press_idx_c(press_idx_c),
    .release_c  (release_c)
  );

  // Press/release FSM with event decode.
  always_comb begin
    state_next = state;
    newhex_d   = 1'b0;
    newop_d    = 1'b0;
    eq_d       = 1'b0;
    bs_d       = 1'b0;
    clr_d      = 1'b0;
    hexcode_d  = hexcode;
    opcode_d   = opcode;
    case (state)
      IDLE: begin
        if (press_c) begin
          state_next = HELD;
          if (press_idx_c <= KEY_HEX_LAST) begin
            newhex_d  = 1'b1;
            hexcode_d = press_idx_c[3:0];
          end else begin
            case (press_idx_c)
              KEY_ADD: begin newop_d = 1'b1; opcode_d = OP_ADD; end
              KEY_SUB: begin newop_d = 1'b1; opcode_d = OP_SUB; end
              KEY_MUL: begin newop_d = 1'b1; opcode_d = OP_MUL; end
              KEY_EQ:  eq_d  = 1'b1;
              KEY_BS:  bs_d  = 1'b1;
              KEY_CLR: clr_d = 1'b1;
              default: ;
            endcase
          end
        end
      end
      HELD: begin
        if (release_c) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      newhex  <= 1'b0;
      newop   <= 1'b0;
      eq      <= 1'b0;
      BS      <= 1'b0;
      clr     <= 1'b0;
      hexcode <= '0;
      opcode  <= '0;
    end else begin
      state   <= state_next;
      newhex  <= newhex_d;
      newop   <= newop_d;
      eq      <= eq_d;
      BS      <= bs_d;
      clr     <= clr_d;
      hexcode <= hexcode_d;
      opcode  <= opcode_d;
    end
  end

endmodule
